mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes the mult, multu, div, divu, mthi and mtlo instructions classified by the decode stage, and owns the architectural HI/LO registers.
- Exposes Busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in ID.
- Accepts Cancel from the exception logic so a faulting or interrupted instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, Busy-high cycles for mult/multu (and madd-family when enabled); legal range >= 1.
DIV_CYCLES, 10, Busy-high cycles for div/divu; legal range >= 1.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Start  input  1  MDOp/A/B valid this cycle
MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 reserved
A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
B  input  32  rt operand (divisor / multiplier)
Cancel  input  1  exception or interrupt taken this cycle; suppresses Start
Busy  output  1  operation in progress
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset: at the clk edge with reset=1, HI=0, LO=0, Busy=0, counter=0, pending results cleared. An in-flight operation is aborted and its result is discarded.
- Accept: an op is accepted at edge t0 iff Start=1, Cancel=0, Busy=0 and MDOp is a legal code.
  - Start while Busy=1 is ignored.
  - Start with Cancel=1 is ignored.
  - Reserved MDOp codes and MDOp=0 are no-ops.
- mthi/mtlo: write A into HI/LO at t0. Busy stays 0. Zero latency.
- mult/multu/div/divu:
  - At t0, A and B are latched and the result is computed into pending hi/lo registers. Operands may change after t0.
  - counter is loaded with N, where N=MULT_CYCLES or DIV_CYCLES.
  - Busy=1 for exactly N cycles after t0.
  - At the edge where counter reaches 0, HI/LO take the pending values and Busy falls in the same edge.
  - HI/LO keep their old values while Busy=1.
- mult: signed 32x32->64; {HI,LO}=product. multu: unsigned.
- div:
  - Signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: Busy still runs for DIV_CYCLES, and HI/LO are left unchanged at completion.
- Cancel asserted while Busy=1 does not abort the op. The op was committed at t0, and the pipeline guarantees only non-excepting instructions reach Start.
- Busy back-to-back: a new Start is accepted in the cycle Busy reads 0 again.

Optional Feature:
MDU_MADD_EN
- Defined:
  - MDOp 7-10 are legal.
  - madd: {HI,LO} += signed A*B. maddu: unsigned variant.
  - msub: {HI,LO} -= signed A*B. msubu: unsigned variant.
  - 64-bit wrap-around.
  - The accumulate base is the HI/LO value at t0. Latency is MULT_CYCLES; timing is otherwise identical to mult.
- Undefined: MDOp 7-10 are treated as reserved no-ops, and no accumulate logic is synthesised.

Test Plan:
1. mult A=0xFFFFFFFF B=0x00000002 -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu -> HI=0x00000001, LO=0xFFFFFFFE.
2. div A=0xFFFFFFF9 (-7) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
3. Preload HI=0x11, LO=0x22 via mthi/mtlo, then div A=5 B=0 -> Busy high 10 cycles; HI=0x11, LO=0x22 afterwards.
4. mthi A=0x1234 -> HI=0x1234 at the next edge, Busy stays 0. Start mtlo A=0x5678 with Cancel=1 -> LO unchanged. Start mult with Cancel=1 -> Busy stays 0.
5. div started; at cycle 2 issue Start mult A=3 B=3 -> ignored, div result lands at cycle 10. Then reset asserted at cycle 3 of a fresh div -> next edge Busy=0, HI=LO=0, and no late write-back occurs.
6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, maddu A=1 B=1 -> after 5 cycles HI=1, LO=0. Then msub A=1 B=2 -> HI=0, LO=0xFFFFFFFE. Without the macro the same MDOp leaves HI/LO unchanged and Busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (MDOp 7-10).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             op_legal, op_long, op_div, op_signed;
  logic             accept, done;
  logic [63:0]      a_ext, b_ext, prod;
  logic             a_neg, b_neg;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [63:0]      res;
  logic             res_we;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_we;

  // Opcode classification
  always_comb begin
    op_legal  = 1'b0;
    op_long   = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    case (MDOp)
      OP_MULT:  begin op_legal = 1'b1; op_long = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_legal = 1'b1; op_long = 1'b1; end
      OP_DIV:   begin op_legal = 1'b1; op_long = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  begin op_legal = 1'b1; op_long = 1'b1; op_div = 1'b1; end
      OP_MTHI, OP_MTLO: op_legal = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:   begin op_legal = 1'b1; op_long = 1'b1; op_signed = 1'b1; end
      OP_MADDU, OP_MSUBU: begin op_legal = 1'b1; op_long = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept = Start && !Cancel && (state == S_IDLE) && op_legal;
  assign done   = (state == S_RUN) && (count == CNT_W'(1));
  assign Busy   = (state == S_RUN);

  // One 64-bit multiplier; sign extension gives the signed product in the low 64 bits
  assign a_ext = {{32{op_signed & A[31]}}, A};
  assign b_ext = {{32{op_signed & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Signed divide done in sign-magnitude form so INT_MIN / -1 wraps naturally
  assign a_neg  = (MDOp == OP_DIV) && A[31];
  assign b_neg  = (MDOp == OP_DIV) && B[31];
  assign a_mag  = a_neg ? (~A + 32'd1) : A;
  assign b_mag  = b_neg ? (~B + 32'd1) : B;
  assign b_safe = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res    = prod;
    res_we = 1'b1;
    case (MDOp)
      OP_DIV, OP_DIVU: begin
        res    = {rem, quot};
        res_we = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: res = {HI, LO} + prod;
      OP_MSUB, OP_MSUBU: res = {HI, LO} - prod;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Busy sequencing: load the latency at accept, drop Busy when the count expires
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        if (accept && op_long) begin
          state_nxt = S_RUN;
          count_nxt = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      S_RUN: begin
        count_nxt = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else if (accept) begin
      if (MDOp == OP_MTHI) HI <= A;
      else if (MDOp == OP_MTLO) LO <= A;
      else begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_we <= res_we;
      end
    end else if (done && pend_we) begin
      HI <= pend_hi;
      LO <= pend_lo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, cancel, busy;
  logic [3:0]  mdop;
  logic [31:0] a, b, hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(start), .MDOp(mdop), .A(a), .B(b),
    .Cancel(cancel), .Busy(busy), .HI(hi), .LO(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_legal(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1) && (op <= 4'd10);
`else
    return (op >= 4'd1) && (op <= 4'd6);
`endif
  endfunction

  // Issue one op at the current negedge, measure Busy length, then check HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ai,
                        input logic [31:0] bi, input bit can);
    logic [63:0] res, prod_s, prod_u;
    longint sa, sb;
    bit acc, div0;
    int unsigned n_exp;
    int cnt;
    sa     = longint'($signed(ai));
    sb     = longint'($signed(bi));
    prod_s = 64'(sa * sb);
    prod_u = {32'd0, ai} * {32'd0, bi};
    acc    = !can && is_legal(op);
    div0   = (op == 4'd3 || op == 4'd4) && (bi == 32'd0);
    res    = {m_hi, m_lo};
    case (op)
      4'd1: res = prod_s;
      4'd2: res = prod_u;
      4'd3: if (!div0) res = {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (!div0) res = {ai % bi, ai / bi};
      4'd5: res = {ai, m_lo};
      4'd6: res = {m_hi, ai};
      4'd7: res = {m_hi, m_lo} + prod_s;
      4'd8: res = {m_hi, m_lo} + prod_u;
      4'd9: res = {m_hi, m_lo} - prod_s;
      4'd10: res = {m_hi, m_lo} - prod_u;
      default: ;
    endcase
    n_exp = 0;
    if (acc && !(op == 4'd5 || op == 4'd6)) n_exp = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
    if (acc) {m_hi, m_lo} = res;

    start = 1'b1; mdop = op; a = ai; b = bi; cancel = can;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; mdop = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(cnt), 64'(n_exp));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    int cnt;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; mdop = '0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("mult_hi_lit", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo_lit", 64'(lo), 64'hFFFFFFFE);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("multu_hi_lit", 64'(hi), 64'h1);
    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
    check("div_neg_lo_lit", 64'(lo), 64'hFFFFFFFD);
    check("div_neg_hi_lit", 64'(hi), 64'hFFFFFFFF);
    run_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_lit", 64'(lo), 64'd3);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo_lit", 64'(lo), 64'h80000000);
    check("div_ovf_hi_lit", 64'(hi), 64'h0);

    run_op("mthi11", 4'd5, 32'h11, 32'h0, 1'b0);
    run_op("mtlo22", 4'd6, 32'h22, 32'h0, 1'b0);
    run_op("div0", 4'd3, 32'd5, 32'd0, 1'b0);
    check("div0_hi_lit", 64'(hi), 64'h11);
    check("div0_lo_lit", 64'(lo), 64'h22);

    run_op("mthi", 4'd5, 32'h1234, 32'h0, 1'b0);
    check("mthi_lit", 64'(hi), 64'h1234);
    run_op("mtlo_cancel", 4'd6, 32'h5678, 32'h0, 1'b1);
    run_op("mult_cancel", 4'd1, 32'd3, 32'd3, 1'b1);
    run_op("reserved", 4'd13, 32'd3, 32'd3, 1'b0);

    // Start during Busy is ignored; the div still completes on schedule
    start = 1'b1; mdop = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b1; mdop = 4'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cnt = 2;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    m_hi = 32'd2; m_lo = 32'd14;
    check("ovl_busy", 64'(cnt), 64'(DIV_N));
    check("ovl_hi", 64'(hi), 64'd2);
    check("ovl_lo", 64'(lo), 64'd14);
    repeat (MULT_N + 2) @(negedge clk);
    check("ovl_noextra", {busy, hi, lo}, {1'b0, 32'd2, 32'd14});

    // Reset mid-operation discards the pending result
    start = 1'b1; mdop = 4'd4; a = 32'd99; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (DIV_N + 2) @(negedge clk);
    check("rst_mid_late", {busy, hi, lo}, 65'd0);

    run_op("p6_mthi", 4'd5, 32'h0, 32'h0, 1'b0);
    run_op("p6_mtlo", 4'd6, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    check("maddu_lit", {hi, lo}, 64'h1_00000000);
`else
    check("maddu_lit", {hi, lo}, 64'h0_FFFFFFFF);
`endif
    run_op("msub", 4'd9, 32'd1, 32'd2, 1'b0);
`ifdef MDU_MADD_EN
    check("msub_lit", {hi, lo}, 64'h0_FFFFFFFE);
`else
    check("msub_lit", {hi, lo}, 64'h0_FFFFFFFF);
`endif

    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rop = 4'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
